// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer and its writeback selector.
package reorder_buffer_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned RB_SIZE   = 8;
  localparam int unsigned RB_INDEX  = 4;
  localparam int unsigned FU_NUM    = 4;
  localparam int unsigned REG_INDEX = 5;
  localparam int unsigned RB_CNT_W  = RB_INDEX + 1;

  // Tag codes that never name a real entry.
  localparam logic [RB_INDEX-1:0] READY = RB_INDEX'(14);
  localparam logic [RB_INDEX-1:0] NULL  = RB_INDEX'(15);

  function automatic logic [RB_INDEX-1:0] rob_next_ptr(input logic [RB_INDEX-1:0] p);
    return (p == RB_INDEX'(RB_SIZE - 1)) ? '0 : p + RB_INDEX'(1);
  endfunction

endpackage

// File: rtl/rob_wb_select.sv
// Priority select of FU result slots onto buffer entries; the lowest slot wins a tie.
module rob_wb_select
  import reorder_buffer_pkg::*;
(
  input  logic [FU_NUM*WORD_SIZE-1:0]  i_data_bus,
  input  logic [FU_NUM-1:0]            i_valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]   i_index_bus,
  output logic [RB_SIZE-1:0]           o_hit,
  output logic [RB_SIZE*WORD_SIZE-1:0] o_data
);

  // Walk slots from highest to lowest so the lowest matching slot is applied last.
  always_comb begin
    o_hit  = '0;
    o_data = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      for (int k = FU_NUM - 1; k >= 0; k--) begin
        if (i_valid_bus[k] && (i_index_bus[k*RB_INDEX +: RB_INDEX] == RB_INDEX'(i))) begin
          o_hit[i]                        = 1'b1;
          o_data[i*WORD_SIZE +: WORD_SIZE] = i_data_bus[k*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: captures FU results, broadcasts them, retires in order,
// and flushes everything on a taken branch.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_dest,
  input  logic                          alloc_is_branch,
  output logic [RB_INDEX-1:0]           alloc_index,
  output logic                          full,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [FU_NUM-1:0]             reset_bus,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic                          flush
);

  logic [RB_SIZE-1:0]   r_busy, r_ready, r_is_branch;
  logic [REG_INDEX-1:0] r_dest  [RB_SIZE];
  logic [WORD_SIZE-1:0] r_value [RB_SIZE];
  logic [RB_INDEX-1:0]  r_head, r_tail;
  logic [RB_CNT_W-1:0]  r_count;
  logic                 r_commit_valid, r_flush;
  logic [REG_INDEX-1:0] r_commit_reg;
  logic [WORD_SIZE-1:0] r_commit_data;
  logic [FU_NUM-1:0]    r_reset_bus;

  logic [RB_SIZE-1:0]           w_head_sel, w_tail_sel, w_wb_hit;
  logic [RB_SIZE*WORD_SIZE-1:0] w_wb_data;
  logic [REG_INDEX-1:0]         w_h_dest;
  logic [WORD_SIZE-1:0]         w_h_value;
  logic w_h_busy, w_h_ready, w_h_branch;
  logic w_retire, w_flush_now, w_commit_wr, w_pop, w_full, w_alloc;

  rob_wb_select u_wb_select (
    .i_data_bus  (data_bus),
    .i_valid_bus (valid_bus),
    .i_index_bus (RB_index_bus),
    .o_hit       (w_wb_hit),
    .o_data      (w_wb_data)
  );

  // Pointer decode and head-entry fields.
  always_comb begin
    w_head_sel = '0;
    w_tail_sel = '0;
    w_h_dest   = '0;
    w_h_value  = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      w_head_sel[i] = (r_head == RB_INDEX'(i));
      w_tail_sel[i] = (r_tail == RB_INDEX'(i));
      if (w_head_sel[i]) begin
        w_h_dest  = r_dest[i];
        w_h_value = r_value[i];
      end
    end
    w_h_busy   = |(r_busy & w_head_sel);
    w_h_ready  = |(r_ready & w_head_sel);
    w_h_branch = |(r_is_branch & w_head_sel);
  end

  assign w_retire    = w_h_busy & w_h_ready;
  assign w_flush_now = w_retire & w_h_branch & w_h_value[0];
  assign w_commit_wr = w_retire & ~w_h_branch;
  assign w_pop       = w_retire & ~w_flush_now;
  assign w_full      = (r_count == RB_CNT_W'(RB_SIZE));
  assign w_alloc     = alloc_req & ~w_full & ~w_flush_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_is_branch    <= '0;
      for (int i = 0; i < RB_SIZE; i++) begin
        r_dest[i]  <= '0;
        r_value[i] <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_reg   <= '0;
      r_commit_data  <= '0;
      r_flush        <= 1'b0;
      r_reset_bus    <= '1;
    end else begin
      r_commit_valid <= w_commit_wr;
      r_flush        <= w_flush_now;
      r_reset_bus    <= {FU_NUM{w_flush_now}};
      if (w_commit_wr) begin
        r_commit_reg  <= w_h_dest;
        r_commit_data <= w_h_value;
      end
      if (w_flush_now) begin
        r_busy      <= '0;
        r_ready     <= '0;
        r_is_branch <= '0;
        for (int i = 0; i < RB_SIZE; i++) begin
          r_dest[i]  <= '0;
          r_value[i] <= '0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        // Alloc, retire and writeback can never target the same entry in one cycle.
        for (int i = 0; i < RB_SIZE; i++) begin
          if (w_alloc && w_tail_sel[i]) begin
            r_busy[i]      <= 1'b1;
            r_ready[i]     <= 1'b0;
            r_is_branch[i] <= alloc_is_branch;
            r_dest[i]      <= alloc_dest;
          end else if (w_pop && w_head_sel[i]) begin
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
          end else if (w_wb_hit[i] && r_busy[i] && !r_ready[i]) begin
            r_value[i] <= w_wb_data[i*WORD_SIZE +: WORD_SIZE];
            r_ready[i] <= 1'b1;
          end
        end
        if (w_pop)   r_head <= rob_next_ptr(r_head);
        if (w_alloc) r_tail <= rob_next_ptr(r_tail);
        case ({w_alloc, w_pop})
          2'b10:   r_count <= r_count + RB_CNT_W'(1);
          2'b01:   r_count <= r_count - RB_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    CDB_data_data = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = r_value[i];
    end
  end

  assign CDB_data_valid = r_busy & r_ready;
  assign alloc_index    = r_tail;
  assign full           = w_full;
  assign reset_bus      = r_reset_bus;
  assign commit_valid   = r_commit_valid;
  assign commit_reg     = r_commit_reg;
  assign commit_data    = r_commit_data;
  assign flush          = r_flush;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits go into a queue that a
// forked monitor drains whenever commit_valid is seen.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                         clk;
  logic                         reset;
  logic                         alloc_req;
  logic [REG_INDEX-1:0]         alloc_dest;
  logic                         alloc_is_branch;
  logic [RB_INDEX-1:0]          alloc_index;
  logic                         full;
  logic [FU_NUM*WORD_SIZE-1:0]  data_bus;
  logic [FU_NUM-1:0]            valid_bus;
  logic [FU_NUM*RB_INDEX-1:0]   RB_index_bus;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [FU_NUM-1:0]            reset_bus;
  logic                         commit_valid;
  logic [REG_INDEX-1:0]         commit_reg;
  logic [WORD_SIZE-1:0]         commit_data;
  logic                         flush;

  typedef struct packed {
    logic [REG_INDEX-1:0] r;
    logic [WORD_SIZE-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_dest     (alloc_dest),
    .alloc_is_branch(alloc_is_branch),
    .alloc_index    (alloc_index),
    .full           (full),
    .data_bus       (data_bus),
    .valid_bus      (valid_bus),
    .RB_index_bus   (RB_index_bus),
    .CDB_data_data  (CDB_data_data),
    .CDB_data_valid (CDB_data_valid),
    .reset_bus      (reset_bus),
    .commit_valid   (commit_valid),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_fu();
    valid_bus    = '0;
    data_bus     = '0;
    RB_index_bus = {FU_NUM{NULL}};
  endtask

  task automatic wb(input int k, input logic [RB_INDEX-1:0] idx, input logic [WORD_SIZE-1:0] d);
    valid_bus[k]                          = 1'b1;
    RB_index_bus[k*RB_INDEX +: RB_INDEX]  = idx;
    data_bus[k*WORD_SIZE +: WORD_SIZE]    = d;
  endtask

  task automatic alloc(input logic [REG_INDEX-1:0] dest, input logic br);
    alloc_req       = 1'b1;
    alloc_dest      = dest;
    alloc_is_branch = br;
    step();
    alloc_req       = 1'b0;
    alloc_is_branch = 1'b0;
  endtask

  task automatic push(input logic [REG_INDEX-1:0] r, input logic [WORD_SIZE-1:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic drain(input string name, input int bound);
    for (int c = 0; c < bound; c++) begin
      if (exp_q.size() == 0) break;
      step();
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    alloc_req = 1'b0;
    alloc_dest = '0;
    alloc_is_branch = 1'b0;
    clear_fu();

    // Commit monitor: every commit_valid must match the oldest expected retire.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (commit_valid === 1'b1) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL commit_unexpected: got reg %0d data %0h expected none", commit_reg, commit_data);
          end else begin
            e = exp_q.pop_front();
            if (commit_reg === e.r && commit_data === e.d) n_pass++;
            else $display("FAIL commit: got reg %0d data %0h expected reg %0d data %0h",
                          commit_reg, commit_data, e.r, e.d);
          end
        end
      end
    join_none

    // Reset
    step();
    step();
    reset = 1'b0;
    check("rst_reset_bus", 64'(reset_bus), 64'hF);
    check("rst_cdb_valid", 64'(CDB_data_valid), 64'd0);
    check("rst_cdb_data_zero", 64'(CDB_data_data == '0), 64'd1);
    check("rst_alloc_index", 64'(alloc_index), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_commit", 64'({commit_valid, commit_reg, commit_data, flush}), 64'd0);
    step();
    check("rst_reset_bus_low", 64'(reset_bus), 64'd0);

    // Basic flow
    alloc(5'd3, 1'b0);
    check("basic_alloc_index", 64'(alloc_index), 64'd1);
    wb(1, 4'd0, 32'h0000_0042);
    push(5'd3, 32'h42);
    step();
    clear_fu();
    check("basic_cdb_valid", 64'(CDB_data_valid), 64'h01);
    check("basic_cdb_data", 64'(CDB_data_data[0 +: WORD_SIZE]), 64'h42);
    step();
    check("basic_cdb_freed", 64'(CDB_data_valid), 64'h00);
    drain("basic_drain", 5);

    // Out of order completion
    do_reset();
    push(5'd5, 32'h200);
    push(5'd6, 32'h211);
    push(5'd7, 32'h222);
    alloc(5'd5, 1'b0);
    alloc(5'd6, 1'b0);
    alloc(5'd7, 1'b0);
    check("ooo_alloc_index", 64'(alloc_index), 64'd3);
    wb(0, 4'd2, 32'h222);
    step();
    clear_fu();
    check("ooo_cdb_valid_2", 64'(CDB_data_valid), 64'h04);
    wb(1, 4'd0, 32'h200);
    step();
    clear_fu();
    check("ooo_cdb_valid_20", 64'(CDB_data_valid), 64'h05);
    wb(2, 4'd1, 32'h211);
    step();
    clear_fu();
    check("ooo_cdb_valid_21", 64'(CDB_data_valid), 64'h06);
    drain("ooo_drain", 6);
    check("ooo_empty_valid", 64'(CDB_data_valid), 64'h00);

    // Full and wrap
    do_reset();
    for (int i = 0; i < RB_SIZE; i++) alloc(REG_INDEX'(i), 1'b0);
    check("full_set", 64'(full), 64'd1);
    check("full_index", 64'(alloc_index), 64'd0);
    alloc(5'd31, 1'b0);
    check("full_ignored_full", 64'(full), 64'd1);
    check("full_ignored_index", 64'(alloc_index), 64'd0);
    push(5'd0, 32'h77);
    wb(0, 4'd0, 32'h77);
    step();
    clear_fu();
    step();
    check("wrap_not_full", 64'(full), 64'd0);
    alloc(5'd9, 1'b0);
    check("wrap_full_again", 64'(full), 64'd1);
    check("wrap_index", 64'(alloc_index), 64'd1);
    for (int k = 0; k < FU_NUM; k++) begin
      wb(k, RB_INDEX'(k + 1), WORD_SIZE'(32'h101 + k));
      push(REG_INDEX'(k + 1), WORD_SIZE'(32'h101 + k));
    end
    step();
    clear_fu();
    wb(0, 4'd5, 32'h105);
    wb(1, 4'd6, 32'h106);
    wb(2, 4'd7, 32'h107);
    wb(3, 4'd0, 32'h100);
    push(5'd5, 32'h105);
    push(5'd6, 32'h106);
    push(5'd7, 32'h107);
    push(5'd9, 32'h100);
    step();
    clear_fu();
    drain("wrap_drain", 20);
    check("wrap_end_full", 64'(full), 64'd0);
    check("wrap_end_index", 64'(alloc_index), 64'd1);
    check("wrap_end_valid", 64'(CDB_data_valid), 64'h00);

    // Taken branch
    do_reset();
    alloc(5'd0, 1'b1);
    alloc(5'd4, 1'b0);
    wb(0, 4'd1, 32'h55);
    step();
    clear_fu();
    check("br_cdb_1", 64'(CDB_data_valid), 64'h02);
    wb(3, 4'd0, 32'h1);
    step();
    clear_fu();
    check("br_cdb_01", 64'(CDB_data_valid), 64'h03);
    check("br_no_flush_yet", 64'(flush), 64'd0);
    alloc_req = 1'b1;
    alloc_dest = 5'd2;
    step();
    check("br_flush", 64'(flush), 64'd1);
    check("br_reset_bus", 64'(reset_bus), 64'hF);
    check("br_cleared", 64'(CDB_data_valid), 64'h00);
    check("br_index_zero", 64'(alloc_index), 64'd0);
    step();
    alloc_req = 1'b0;
    check("br_flush_low", 64'(flush), 64'd0);
    check("br_reset_bus_low", 64'(reset_bus), 64'd0);
    check("br_realloc_index", 64'(alloc_index), 64'd1);
    wb(0, 4'd0, 32'h99);
    push(5'd2, 32'h99);
    step();
    clear_fu();
    drain("br_drain", 5);

    // Not-taken branch retires silently
    do_reset();
    alloc(5'd1, 1'b1);
    alloc(5'd8, 1'b0);
    wb(0, 4'd0, 32'h2);
    wb(1, 4'd1, 32'hABC);
    push(5'd8, 32'hABC);
    step();
    clear_fu();
    drain("nt_drain", 6);
    check("nt_index", 64'(alloc_index), 64'd2);
    check("nt_valid", 64'(CDB_data_valid), 64'h00);

    // Writeback conflicts and ignored tags
    do_reset();
    alloc(5'd10, 1'b0);
    alloc(5'd11, 1'b0);
    wb(0, 4'd1, 32'h1111);
    wb(2, 4'd1, 32'h2222);
    wb(1, NULL, 32'hDEAD);
    wb(3, 4'd9, 32'hBEEF);
    step();
    clear_fu();
    check("wbc_valid", 64'(CDB_data_valid), 64'h02);
    check("wbc_data", 64'(CDB_data_data[1*WORD_SIZE +: WORD_SIZE]), 64'h1111);
    wb(0, 4'd1, 32'h3333);
    wb(1, 4'd5, 32'h5555);
    step();
    clear_fu();
    check("wbc_ready_kept", 64'(CDB_data_data[1*WORD_SIZE +: WORD_SIZE]), 64'h1111);
    check("wbc_idle_ignored", 64'(CDB_data_valid), 64'h02);
    wb(2, 4'd0, 32'h1010);
    push(5'd10, 32'h1010);
    push(5'd11, 32'h1111);
    step();
    clear_fu();
    drain("wbc_drain", 6);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
